// File: rtl/token_decoder_pkg.sv
// token_decoder_pkg
//   Shared definitions for the token decoder (and the matching encoder):
//   FSM state encoding, default RAM geometry and the end-of-stream token.
//   No ports.
package token_decoder_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Wide all-ones source; the top truncates it to DATA_WIDTH to form TERM.
    localparam logic [63:0] TERM_ALL_ONES = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TOK_RD  = 3'd1,
        TOK_CHK = 3'd2,
        CH_RD   = 3'd3,
        CH_CHK  = 3'd4,
        DONE    = 3'd5
    } decoder_state;

endpackage

// File: rtl/token_decoder.sv
// token_decoder
//   Expands a stream of token IDs (vocabulary start addresses) back into
//   text: each token's zero-terminated word is copied from the vocabulary
//   RAM into the output RAM, followed by a single 0 separator.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for cs; busy low
//   TOK_RD  | token RAM read in flight
//   TOK_CHK | token valid: TERM ends the stream, else point voc_addr at it
//   CH_RD   | vocabulary RAM read in flight
//   CH_CHK  | character valid: copy it, or write separator and next token
//   DONE    | one-cycle done pulse
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cs                     start request (sampled in IDLE only)
//   tok_addr / tok_dout    token RAM read port (1-cycle read latency)
//   voc_addr / voc_dout    vocabulary RAM read port (1-cycle read latency)
//   out_addr/out_din/out_we output RAM write port (registered)
//   busy, done             status; done is a one-cycle pulse
//   overflow               sticky until next cs: output RAM full
//   out_count              writes performed, saturates at 2^ADDR_WIDTH
module token_decoder
    import token_decoder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TERM = DATA_WIDTH'(TERM_ALL_ONES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_dout,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_we,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   out_count
);

    localparam logic [ADDR_WIDTH:0] OUT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    decoder_state state, state_nxt;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    // Set after copying the character at the last vocabulary address; the
    // next CH_CHK then behaves as if a terminator had been read, so the word
    // ends at the boundary instead of wrapping voc_addr.
    logic                  voc_end;

    logic is_term, full, ch_zero, tok_last, voc_last;

    assign is_term  = (tok_dout == TERM);
    assign full     = (out_count == OUT_FULL);
    assign ch_zero  = voc_end || (voc_dout == '0);
    assign tok_last = (tok_addr == '1);
    assign voc_last = (voc_addr == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cs) state_nxt = TOK_RD;
            TOK_RD:  state_nxt = TOK_CHK;
            TOK_CHK: state_nxt = is_term ? DONE : CH_RD;
            CH_RD:   state_nxt = CH_CHK;
            CH_CHK: begin
                if (full)          state_nxt = DONE;
                else if (!ch_zero) state_nxt = CH_RD;
                else if (tok_last) state_nxt = DONE;
                else               state_nxt = TOK_RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_addr  <= '0;
            voc_addr  <= '0;
            out_addr  <= '0;
            out_din   <= '0;
            out_we    <= 1'b0;
            overflow  <= 1'b0;
            out_count <= '0;
            wr_ptr    <= '0;
            voc_end   <= 1'b0;
        end else begin
            out_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs) begin
                        tok_addr  <= '0;
                        voc_addr  <= '0;
                        wr_ptr    <= '0;
                        out_count <= '0;
                        overflow  <= 1'b0;
                        voc_end   <= 1'b0;
                    end
                end
                TOK_CHK: begin
                    if (!is_term) begin
                        voc_addr <= tok_dout[ADDR_WIDTH-1:0];
                        voc_end  <= 1'b0;
                    end
                end
                CH_CHK: begin
                    if (full) begin
                        // Write suppressed; out_count is already saturated.
                        overflow <= 1'b1;
                    end else begin
                        out_we    <= 1'b1;
                        out_addr  <= wr_ptr;
                        wr_ptr    <= wr_ptr + 1'b1;
                        out_count <= out_count + 1'b1;
                        if (ch_zero) begin
                            out_din <= '0;
                            voc_end <= 1'b0;
                            if (!tok_last) tok_addr <= tok_addr + 1'b1;
                        end else begin
                            out_din <= voc_dout;
                            if (voc_last) voc_end  <= 1'b1;
                            else          voc_addr <= voc_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_token_decoder.sv
module tb_token_decoder;
    import token_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic [3:0] tok_addr, voc_addr, out_addr;
    logic [7:0] tok_dout, voc_dout, out_din;
    logic       out_we, busy, done, overflow;
    logic [4:0] out_count;

    token_decoder dut (
        .clk(clk), .rst_n(rst_n), .cs(cs),
        .tok_addr(tok_addr), .tok_dout(tok_dout),
        .voc_addr(voc_addr), .voc_dout(voc_dout),
        .out_addr(out_addr), .out_din(out_din), .out_we(out_we),
        .busy(busy), .done(done), .overflow(overflow), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM models
    logic [7:0] tok_mem [16];
    logic [7:0] voc_mem [16];
    logic [7:0] out_mem [16];

    always @(posedge clk) begin
        tok_dout <= tok_mem[tok_addr];
        voc_dout <= voc_mem[voc_addr];
        if (out_we) out_mem[out_addr] <= out_din;
    end

    // Write log and voc_addr wrap monitor
    int wlog_d[$];
    int wlog_a[$];
    int wrap_cnt = 0;
    logic [3:0] prev_voc = '0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (out_we) begin
            wlog_d.push_back(int'(out_din));
            wlog_a.push_back(int'(out_addr));
        end
        if (busy && prev_busy && prev_voc == 4'd15 && voc_addr == 4'd0) wrap_cnt++;
        prev_voc  = voc_addr;
        prev_busy = busy;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int scen;
        bit hold;
        int lat;
        int cnt;
        int ovf;
    } vec_t;

    int exp_d[$];

    // Scenario loader: fills RAMs and the hand-computed expected write stream.
    task automatic setup(input int s);
        for (int i = 0; i < 16; i++) begin
            tok_mem[i] = 8'hFF;
            voc_mem[i] = 8'h00;
        end
        exp_d = {};
        case (s)
            0: begin // basic "hi" "a"
                voc_mem[0] = "h"; voc_mem[1] = "i"; voc_mem[2] = 8'h00;
                voc_mem[3] = "a"; voc_mem[4] = 8'h00;
                tok_mem[0] = 8'd0; tok_mem[1] = 8'd3; tok_mem[2] = 8'hFF;
                exp_d = {"h", "i", 0, "a", 0};
            end
            1: begin // empty stream
                tok_mem[0] = 8'hFF;
            end
            2: begin // overflow: 7-char word three times
                for (int i = 0; i < 7; i++) voc_mem[i] = 8'(int'("a") + i);
                voc_mem[7] = 8'h00;
                tok_mem[0] = 8'd0; tok_mem[1] = 8'd0; tok_mem[2] = 8'd0; tok_mem[3] = 8'hFF;
                for (int r = 0; r < 2; r++) begin
                    for (int i = 0; i < 7; i++) exp_d.push_back(int'("a") + i);
                    exp_d.push_back(0);
                end
            end
            3: begin // token RAM exhausted, all empty words
                for (int i = 0; i < 16; i++) tok_mem[i] = 8'd5;
                for (int i = 0; i < 16; i++) exp_d.push_back(0);
            end
            4: begin // vocabulary boundary, no terminator
                voc_mem[14] = "x"; voc_mem[15] = "y";
                tok_mem[0] = 8'd14; tok_mem[1] = 8'hFF;
                exp_d = {"x", "y", 0};
            end
            default: ;
        endcase
    endtask

    task automatic run(input bit hold, output int lat);
        lat = -1;
        @(negedge clk);
        cs = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!hold) cs = 1'b0;
            if (k == 1) chk("busy_after_cs", int'(busy), 1);
            if (done) begin
                lat = k;
                break;
            end
        end
        cs = 1'b0;
        @(negedge clk);
        chk("done_pulse_width", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
    endtask

    task automatic check_writes(input string tag, input int base);
        chk({tag, "_nwrites"}, wlog_d.size() - base, exp_d.size());
        for (int i = 0; i < exp_d.size() && base + i < wlog_d.size(); i++) begin
            chk({tag, "_wdata"}, wlog_d[base + i], exp_d[i]);
            chk({tag, "_waddr"}, wlog_a[base + i], i);
            chk({tag, "_ram"}, int'(out_mem[i]), exp_d[i]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tok_addr"}, int'(tok_addr), 0);
        chk({tag, "_voc_addr"}, int'(voc_addr), 0);
        chk({tag, "_out_addr"}, int'(out_addr), 0);
        chk({tag, "_out_din"}, int'(out_din), 0);
        chk({tag, "_out_we"}, int'(out_we), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_out_count"}, int'(out_count), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int lat, base, wbase;

        // scen, hold_cs, latency (cycles after accepting edge), out_count, overflow
        vecs[0] = '{0, 1'b0, 17, 5, 0};
        vecs[1] = '{1, 1'b0, 3, 0, 0};
        vecs[2] = '{2, 1'b0, 41, 16, 1};
        vecs[3] = '{3, 1'b0, 65, 16, 0};
        vecs[4] = '{4, 1'b0, 11, 3, 0};
        vecs[5] = '{0, 1'b1, 17, 5, 0};

        setup(0);
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            setup(vecs[i].scen);
            base  = wlog_d.size();
            wbase = wrap_cnt;
            run(vecs[i].hold, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_out_count", i), int'(out_count), vecs[i].cnt);
            chk($sformatf("v%0d_overflow", i), int'(overflow), vecs[i].ovf);
            chk($sformatf("v%0d_voc_wrap", i), wrap_cnt - wbase, 0);
            check_writes($sformatf("v%0d", i), base);
        end

        // Reset in the middle of a word, then a clean restart from token 0
        setup(0);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        base = wlog_d.size();
        run(1'b0, lat);
        chk("restart_latency", lat, 17);
        chk("restart_out_count", int'(out_count), 5);
        check_writes("restart", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
